// File: rtl/booth_multiplier_param_pkg.sv
// Shared definitions for the parametrised serial-bus Booth multiplier.
//   state_e    : controller states, IDLE through OUT_LO
//   recode_e   : Booth digit selected for one iteration (0, +/-X, +/-2X)
//   iter_count : number of CALC cycles for a given width and radix
package booth_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_X = 3'd1,
      LOAD_Y = 3'd2,
      CALC   = 3'd3,
      OUT_HI = 3'd4,
      OUT_LO = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      PX   = 3'd1,
      P2X  = 3'd2,
      NX   = 3'd3,
      N2X  = 3'd4
   } recode_e;

   // Operands carry one extension bit, so radix-2 retires WIDTH+1 bits and
   // radix-4 retires ceil((WIDTH+1)/2) digit pairs.
   function automatic int iter_count(input int width, input int radix4);
      return (radix4 != 0) ? (width + 2) / 2 : width + 1;
   endfunction

endpackage

// File: rtl/booth_multiplier_param_if.sv
// Operand/result bus of the Booth multiplier.
//   start       : request a multiplication (honoured only when idle)
//   signed_mode : 1 = two's complement operands, sampled with start
//   in_bus      : X on the first load cycle, Y on the second
//   out_bus     : product high half, then low half; 0 otherwise
//   done        : one-cycle strobe alongside the high half
//   busy        : operation in progress
// master = controller side, slave = multiplier side.
interface booth_multiplier_param_if #(parameter int WIDTH = 6);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] in_bus;
   logic [WIDTH-1:0] out_bus;
   logic             done;
   logic             busy;

   modport master (output start, signed_mode, in_bus,
                   input  out_bus, done, busy);
   modport slave  (input  start, signed_mode, in_bus,
                   output out_bus, done, busy);
endinterface

// File: rtl/booth_multiplier_param_recoder.sv
// Booth window recoder (purely combinational).
//   radix4 : 1 = 3-bit modified Booth window, 0 = 2-bit window in window[1:0]
//   window : {y[i+1], y[i], y[i-1]} (radix-4) or {-, y[i], y[i-1]} (radix-2)
//   nz     : an addend is required this iteration
//   neg    : the addend is subtracted
//   dbl    : the addend is 2X rather than X
module booth_recoder
   import booth_pkg::*;
(
   input  logic       radix4,
   input  logic [2:0] window,
   output logic       nz,
   output logic       neg,
   output logic       dbl
);

   recode_e code;

   always_comb begin
      code = ZERO;
      if (radix4) begin
         case (window)
            3'b001, 3'b010: code = PX;
            3'b011:         code = P2X;
            3'b100:         code = N2X;
            3'b101, 3'b110: code = NX;
            default:        code = ZERO;
         endcase
      end else begin
         case (window[1:0])
            2'b01:   code = PX;
            2'b10:   code = NX;
            default: code = ZERO;
         endcase
      end
   end

   assign nz  = (code != ZERO);
   assign neg = (code == NX)  || (code == N2X);
   assign dbl = (code == P2X) || (code == N2X);

endmodule

// File: rtl/booth_multiplier_param.sv
// Parametrised sequential Booth multiplier on a shared WIDTH-bit bus.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, aborts any operation
//   bus   : slave side of booth_multiplier_param_if (start, signed_mode,
//           in_bus in; out_bus, done, busy out)
// Parameters: WIDTH (4..32) operand width, RADIX4 selects modified Booth.
// Flow: IDLE -start-> LOAD_X -> LOAD_Y -> CALC (ITER cycles) -> OUT_HI -> OUT_LO.
module booth_multiplier_param
   import booth_pkg::*;
#(
   parameter int WIDTH  = 6,
   parameter int RADIX4 = 0
)(
   input  logic                     clk,
   input  logic                     rst_n,
   booth_multiplier_param_if.slave  bus
);

   localparam int ITER = iter_count(WIDTH, RADIX4);
   localparam int XW   = WIDTH + 1;                      // extended operand
   localparam int AW   = WIDTH + 3;                      // room for +/-2X
   localparam int QW   = (RADIX4 != 0) ? 2 * ITER : XW;  // multiplier reg
   localparam int SH   = (RADIX4 != 0) ? 2 : 1;
   localparam int CW   = $clog2(ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   state_e           state_q, state_d;
   logic             sm_q, sm_d;
   logic [XW-1:0]    x_q, x_d;
   logic [AW-1:0]    a_q, a_d;
   logic [QW-1:0]    q_q, q_d;
   logic             qm1_q, qm1_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   // ---------------- Booth step ----------------
   logic [2:0]          window;
   logic                rec_nz, rec_neg, rec_dbl;
   logic [AW-1:0]       x_ext, mag, addend, sum;
   logic signed [AW+QW:0] shift_in, shifted;
   logic [AW-1:0]       a_shf;
   logic [QW-1:0]       q_shf;
   logic                qm1_shf;
   logic                ext_in;

   assign window = (RADIX4 != 0) ? {q_q[1], q_q[0], qm1_q}
                                 : {1'b0,   q_q[0], qm1_q};

   booth_recoder u_rec (
      .radix4 (RADIX4 != 0),
      .window (window),
      .nz     (rec_nz),
      .neg    (rec_neg),
      .dbl    (rec_dbl)
   );

   always_comb begin
      x_ext    = {{(AW-XW){x_q[XW-1]}}, x_q};
      mag      = rec_dbl ? {x_ext[AW-2:0], 1'b0} : x_ext;
      addend   = !rec_nz ? '0 : (rec_neg ? -mag : mag);
      sum      = a_q + addend;
      // {A,Q,q-1} shift as one signed vector so A's sign fills from the top
      shift_in = {sum, q_q, qm1_q};
      shifted  = shift_in >>> SH;
      a_shf    = shifted[AW+QW:QW+1];
      q_shf    = shifted[QW:1];
      qm1_shf  = shifted[0];
   end

   // Extension bit for an operand being loaded; mode was latched at start.
   assign ext_in = sm_q & bus.in_bus[WIDTH-1];

   // ---------------- datapath next-state ----------------
   always_comb begin
      sm_d  = sm_q;
      x_d   = x_q;
      a_d   = a_q;
      q_d   = q_q;
      qm1_d = qm1_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE:   if (bus.start) sm_d = bus.signed_mode;
         LOAD_X: x_d = {ext_in, bus.in_bus};
         LOAD_Y: begin
            q_d   = {{(QW-WIDTH){ext_in}}, bus.in_bus};
            a_d   = '0;
            qm1_d = 1'b0;
            cnt_d = '0;
         end
         CALC: begin
            a_d   = a_shf;
            q_d   = q_shf;
            qm1_d = qm1_shf;
            cnt_d = cnt_q + CW'(1);
         end
         default: ;
      endcase
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = LOAD_X;
         LOAD_X:  state_d = LOAD_Y;
         LOAD_Y:  state_d = CALC;
         CALC:    if (cnt_q == LAST) state_d = OUT_HI;
         OUT_HI:  state_d = OUT_LO;
         OUT_LO:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: registered outputs ----------------
   // Outputs are decoded from the next state so they line up with it. After
   // all ITER shifts the low QW bits of the product sit in Q and the rest in
   // A; a_d/q_d already hold the final value on the edge into OUT_HI and are
   // frozen afterwards.
   always_comb begin
      out_d  = '0;
      done_d = 1'b0;
      busy_d = (state_d != IDLE);
      case (state_d)
         OUT_HI: begin
            out_d  = {a_d[2*WIDTH-QW-1:0], q_d[QW-1:WIDTH]};
            done_d = 1'b1;
         end
         OUT_LO:  out_d = q_d[WIDTH-1:0];
         default: ;
      endcase
   end

   // ---------------- FSM: state and datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sm_q    <= 1'b0;
         x_q     <= '0;
         a_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sm_q    <= sm_d;
         x_q     <= x_d;
         a_q     <= a_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.out_bus = out_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Bench for booth_multiplier_param: four instances (WIDTH 6/8 x radix-2/4).
// Expected results go into a per-instance queue when an operation is issued;
// a negedge monitor per instance pops and compares when done rises.
module tb_booth_multiplier_param;

   logic clk, rst_n;
   logic st6, st8, sm;
   logic [5:0] in6;
   logic [7:0] in8;
   int   cyc = 0;
   int   n_pass, n_tot;

   booth_multiplier_param_if #(.WIDTH(6)) b62 ();
   booth_multiplier_param_if #(.WIDTH(6)) b64 ();
   booth_multiplier_param_if #(.WIDTH(8)) b82 ();
   booth_multiplier_param_if #(.WIDTH(8)) b84 ();

   assign b62.start = st6; assign b62.signed_mode = sm; assign b62.in_bus = in6;
   assign b64.start = st6; assign b64.signed_mode = sm; assign b64.in_bus = in6;
   assign b82.start = st8; assign b82.signed_mode = sm; assign b82.in_bus = in8;
   assign b84.start = st8; assign b84.signed_mode = sm; assign b84.in_bus = in8;

   booth_multiplier_param #(.WIDTH(6), .RADIX4(0)) u62 (.clk(clk), .rst_n(rst_n), .bus(b62));
   booth_multiplier_param #(.WIDTH(6), .RADIX4(1)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
   booth_multiplier_param #(.WIDTH(8), .RADIX4(0)) u82 (.clk(clk), .rst_n(rst_n), .bus(b82));
   booth_multiplier_param #(.WIDTH(8), .RADIX4(1)) u84 (.clk(clk), .rst_n(rst_n), .bus(b84));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] hi; logic [31:0] lo; int cyc; } exp_t;
   typedef struct { int w; bit s; logic [7:0] x, y, hi, lo; } vec_t;

   exp_t        sb[4][$];
   int          ph[4];
   logic [31:0] lo_exp[4];
   int          iters[4] = '{7, 4, 9, 5};
   string       nm[4]    = '{"w6r2", "w6r4", "w8r2", "w8r4"};
   vec_t        tbl[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Per-instance output monitor: high half + done cycle, then low half,
   // then busy must have dropped.
   task automatic mon(input int id, input logic dn, input logic [31:0] ob, input logic bz);
      exp_t e;
      case (ph[id])
         0: begin
            if (dn) begin
               if (sb[id].size() == 0) chk({nm[id], " spurious_done"}, 64'(dn), 0);
               else begin
                  e = sb[id].pop_front();
                  chk({nm[id], " out_hi"}, 64'(ob), 64'(e.hi));
                  chk({nm[id], " done_cycle"}, 64'(cyc), 64'(e.cyc));
                  lo_exp[id] = e.lo;
                  ph[id] = 1;
               end
            end else chk({nm[id], " out_idle"}, 64'(ob), 0);
         end
         1: begin
            chk({nm[id], " out_lo"}, 64'(ob), 64'(lo_exp[id]));
            chk({nm[id], " done_single"}, 64'(dn), 0);
            ph[id] = 2;
         end
         default: begin
            chk({nm[id], " busy_after"}, 64'(bz), 0);
            ph[id] = 0;
         end
      endcase
   endtask

   always @(negedge clk) mon(0, b62.done, 32'(b62.out_bus), b62.busy);
   always @(negedge clk) mon(1, b64.done, 32'(b64.out_bus), b64.busy);
   always @(negedge clk) mon(2, b82.done, 32'(b82.out_bus), b82.busy);
   always @(negedge clk) mon(3, b84.done, 32'(b84.out_bus), b84.busy);

   function automatic logic [63:0] model(input int w, input bit s, input logic [7:0] x, input logic [7:0] y);
      longint xv, yv;
      if (w == 6) begin
         xv = s ? longint'($signed(x[5:0])) : longint'(x[5:0]);
         yv = s ? longint'($signed(y[5:0])) : longint'(y[5:0]);
      end else begin
         xv = s ? longint'($signed(x)) : longint'(x);
         yv = s ? longint'($signed(y)) : longint'(y);
      end
      return 64'(xv * yv);
   endfunction

   task automatic drv(input int w, input logic st, input logic s, input logic [7:0] v);
      sm = s;
      if (w == 6) begin st6 = st; in6 = v[5:0]; end
      else begin st8 = st; in8 = v; end
   endtask

   // Issue one operation to both instances of width w. start is held for
   // 'hold' cycles and re-pulsed at offset 'pulse' (0 = none); in_bus and
   // signed_mode carry junk outside their sampling cycles.
   task automatic op(input int w, input bit s, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] ehi, input logic [7:0] elo, input int hold, input int pulse);
      int c0, span, id0;
      id0  = (w == 6) ? 0 : 2;
      span = ((w == 6) ? 7 : 9) + 6;
      c0   = cyc;
      for (int i = id0; i < id0 + 2; i++)
         sb[i].push_back('{32'(ehi), 32'(elo), c0 + 3 + iters[i]});
      drv(w, 1'b1, s, 8'($urandom));
      for (int k = 1; k <= span; k++) begin
         @(posedge clk); #1;
         drv(w, (k < hold) || (k == pulse), 1'($urandom),
             (k == 1) ? x : ((k == 2) ? y : 8'($urandom)));
      end
      for (int i = id0; i < id0 + 2; i++)
         chk({nm[i], " drained"}, 64'(sb[i].size()), 0);
   endtask

   initial begin
      n_pass = 0; n_tot = 0;
      st6 = 0; st8 = 0; sm = 0; in6 = '0; in8 = '0;
      for (int i = 0; i < 4; i++) ph[i] = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("w6r2 rst_out", 64'(b62.out_bus), 0); chk("w6r2 rst_done", 64'(b62.done), 0); chk("w6r2 rst_busy", 64'(b62.busy), 0);
      chk("w6r4 rst_out", 64'(b64.out_bus), 0); chk("w6r4 rst_done", 64'(b64.done), 0); chk("w6r4 rst_busy", 64'(b64.busy), 0);
      chk("w8r2 rst_out", 64'(b82.out_bus), 0); chk("w8r2 rst_done", 64'(b82.done), 0); chk("w8r2 rst_busy", 64'(b82.busy), 0);
      chk("w8r4 rst_out", 64'(b84.out_bus), 0); chk("w8r4 rst_done", 64'(b84.done), 0); chk("w8r4 rst_busy", 64'(b84.busy), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // {width, signed, x, y, product hi, product lo}
      tbl[0] = '{6, 1'b1, 8'h09, 8'h08, 8'h01, 8'h08};   // 9*8 = 72
      tbl[1] = '{6, 1'b1, 8'h17, 8'h35, 8'h3C, 8'h03};   // 23*-11 = -253
      tbl[2] = '{6, 1'b1, 8'h36, 8'h2D, 8'h02, 8'h3E};   // -10*-19 = 190
      tbl[3] = '{6, 1'b1, 8'h20, 8'h20, 8'h10, 8'h00};   // -32*-32 = 1024
      tbl[4] = '{6, 1'b1, 8'h14, 8'h00, 8'h00, 8'h00};   // 20*0
      tbl[5] = '{6, 1'b0, 8'h3F, 8'h3F, 8'h3E, 8'h01};   // 63*63 = 3969
      tbl[6] = '{8, 1'b1, 8'h80, 8'h7F, 8'hC0, 8'h80};   // -128*127 = -16256
      tbl[7] = '{8, 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01};   // 255*255 = 65025
      tbl[8] = '{8, 1'b1, 8'h80, 8'h80, 8'h40, 8'h00};   // -128*-128 = 16384
      for (int i = 0; i < 9; i++)
         op(tbl[i].w, tbl[i].s, tbl[i].x, tbl[i].y, tbl[i].hi, tbl[i].lo, 1, 0);

      // start held through a whole radix-4 operation, then re-pulsed in CALC
      op(6, 1'b1, 8'h17, 8'h35, 8'h3C, 8'h03, 9, 0);
      op(6, 1'b1, 8'h36, 8'h2D, 8'h02, 8'h3E, 1, 5);
      op(8, 1'b1, 8'h80, 8'h7F, 8'hC0, 8'h80, 1, 6);

      // reset pulse in the middle of CALC: outputs clear at once, no done
      drv(6, 1'b1, 1'b1, 8'h00);
      @(posedge clk); #1; drv(6, 1'b0, 1'b0, 8'h09);
      @(posedge clk); #1; drv(6, 1'b0, 1'b0, 8'h08);
      repeat (2) begin @(posedge clk); #1; end
      chk("w6r2 busy_calc", 64'(b62.busy), 1);
      chk("w6r4 busy_calc", 64'(b64.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("w6r2 arst_out", 64'(b62.out_bus), 0); chk("w6r2 arst_busy", 64'(b62.busy), 0); chk("w6r2 arst_done", 64'(b62.done), 0);
      chk("w6r4 arst_out", 64'(b64.out_bus), 0); chk("w6r4 arst_busy", 64'(b64.busy), 0); chk("w6r4 arst_done", 64'(b64.done), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (14) begin @(posedge clk); #1; end
      op(6, 1'b1, 8'h39, 8'h0D, 8'h3E, 8'h25, 1, 0);    // -7*13 = -91

      // random pairs, mixed modes, against the reference product
      for (int n = 0; n < 1000; n++) begin
         bit s;
         logic [7:0] x, y;
         logic [63:0] p;
         s = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
         p = model(8, s, x, y);
         op(8, s, x, y, p[15:8], p[7:0], 1, 0);
      end
      for (int n = 0; n < 100; n++) begin
         bit s;
         logic [7:0] x, y;
         logic [63:0] p;
         s = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
         p = model(6, s, x, y);
         op(6, s, x, y, 8'(p[11:6]), 8'(p[5:0]), 1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
